// File: rtl/spi_master_multi_if.sv
// Control/status handshake and SPI pin bundle for spi_master_multi.
// master modport is the engine's view; slave is the controller/peripheral side.
interface spi_master_multi_if #(
  parameter int BITS   = 32,
  parameter int LEN_W  = 6,
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2,
  parameter int DIV_W  = 16
);
  logic              start;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic [LEN_W-1:0]  xfer_len;
  logic [DIV_W-1:0]  clk_div;
  logic [BITS-1:0]   tx_data;
  logic [BITS-1:0]   rx_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  start, cs_sel, cpol, cpha, xfer_len, clk_div, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, cs_sel, cpol, cpha, xfer_len, clk_div, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, length, divider and chip select; done pulses (2*len+3)*H+1
// cycles after accept. Inputs are latched at accept and start is ignored while busy.
module spi_master_multi #(
  parameter int BITS   = 32,
  parameter int LEN_W  = 6,
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2,
  parameter int DIV_W  = 16
) (
  input logic               spi_sys_clk,
  input logic               reset,
  spi_master_multi_if.master bus
);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP, FIN} state_t;

  localparam logic [LEN_W:0] BITS_L = (LEN_W + 1)'(BITS);

  state_t            state_q;
  logic              cpol_q, cpha_q;
  logic [DIV_W-1:0]  div_q, hcnt_q;
  logic [LEN_W:0]    ecnt_q;
  logic [BITS-1:0]   tx_q, rx_q, rx_data_q;
  logic              sclk_q, mosi_q, busy_q, done_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic [LEN_W:0]    len_d;
  logic [BITS-1:0]   tx_d;
  logic [NUM_CS-1:0] cs_n_d;
  logic              hexp, tog, lead_edge, drive, sample;

  always_comb begin
    len_d = {1'b0, bus.xfer_len};
    if (bus.xfer_len == '0 || len_d > BITS_L) len_d = BITS_L;
    // Left-align so the first bit to send sits in the MSB
    tx_d = bus.tx_data << (BITS_L - len_d);
    for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (bus.cs_sel != CS_W'(i));
    hexp      = (hcnt_q == '0);
    tog       = hexp && ((state_q == LEAD) || (state_q == SHIFT && ecnt_q != '0));
    lead_edge = (sclk_q == cpol_q);
    drive     = tog && (lead_edge == cpha_q);
    sample    = tog && (lead_edge != cpha_q);
  end

  always_ff @(posedge spi_sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      hcnt_q    <= '0;
      ecnt_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      done_q <= 1'b0;
      if (!hexp) hcnt_q <= hcnt_q - 1'b1;
      if (tog) sclk_q <= ~sclk_q;
      if (drive) begin
        mosi_q <= tx_q[BITS-1];
        tx_q   <= tx_q << 1;
      end
      if (sample) rx_q <= {rx_q[BITS-2:0], bus.miso};

      case (state_q)
        IDLE: begin
          sclk_q <= bus.cpol;
          mosi_q <= 1'b0;
          cs_n_q <= '1;
          if (bus.start) begin
            state_q <= LEAD;
            busy_q  <= 1'b1;
            cpol_q  <= bus.cpol;
            cpha_q  <= bus.cpha;
            div_q   <= bus.clk_div;
            hcnt_q  <= bus.clk_div;
            // First edge is issued on leaving LEAD, so one fewer remains
            ecnt_q  <= (len_d << 1) - 1'b1;
            rx_q    <= '0;
            cs_n_q  <= cs_n_d;
            if (bus.cpha) begin
              tx_q <= tx_d;
            end else begin
              mosi_q <= tx_d[BITS-1];
              tx_q   <= tx_d << 1;
            end
          end
        end
        LEAD: if (hexp) begin
          state_q <= SHIFT;
          hcnt_q  <= div_q;
        end
        SHIFT: if (hexp) begin
          hcnt_q <= div_q;
          if (ecnt_q == '0) begin
            state_q <= TRAIL;
            mosi_q  <= 1'b0;
          end else begin
            ecnt_q <= ecnt_q - 1'b1;
          end
        end
        TRAIL: if (hexp) begin
          state_q <= GAP;
          hcnt_q  <= div_q;
          cs_n_q  <= '1;
        end
        GAP: if (hexp) state_q <= FIN;
        FIN: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          rx_data_q <= rx_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: vector table of single transfers plus
// back-to-back, mid-transfer reset and mid-transfer input changes.
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] miso_mode = 2'd0;   // 0: loopback from mosi, 1: constant 1, 2: constant 0
  int n_chk = 0;
  int n_fail = 0;

  spi_master_multi_if #(.BITS(32), .LEN_W(6), .NUM_CS(4), .CS_W(3), .DIV_W(16)) bus ();

  spi_master_multi #(.BITS(32), .LEN_W(6), .NUM_CS(4), .CS_W(3), .DIV_W(16)) dut (
    .spi_sys_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.miso = (miso_mode == 2'd0) ? bus.mosi : miso_mode[0];

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [5:0]  len;
    logic [15:0] div;
    logic [31:0] tx;
    logic [1:0]  mm;
    logic [2:0]  cs;
    logic        pert;
    logic [31:0] rx;
    int          lat;
    int          edges;
    logic [3:0]  cs_low;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int n = 0;
    int edges = 0;
    int rises = 0;
    logic prev;
    logic [3:0] cs_acc;
    logic got = 1'b0;
    @(negedge clk);
    bus.cpol = v.cpol;
    bus.cpha = v.cpha;
    bus.xfer_len = v.len;
    bus.clk_div = v.div;
    bus.tx_data = v.tx;
    bus.cs_sel = v.cs;
    miso_mode = v.mm;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
    prev = bus.sclk;
    cs_acc = ~bus.cs_n;
    while (!got && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 5 && v.pert) begin
        bus.clk_div = 16'd0;
        bus.tx_data = ~v.tx;
        bus.cpol = ~v.cpol;
        bus.cpha = ~v.cpha;
        bus.xfer_len = 6'd1;
        bus.cs_sel = 3'd1;
      end
      if (bus.sclk !== prev) begin
        edges++;
        if (bus.sclk) rises++;
      end
      prev = bus.sclk;
      cs_acc |= ~bus.cs_n;
      got = bus.done;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(v.lat));
    chk({tag, "_sclk_edges"}, 64'(edges), 64'(v.edges));
    chk({tag, "_sclk_rises"}, 64'(rises), 64'(v.edges / 2));
    chk({tag, "_rx_data"}, 64'(bus.rx_data), 64'(v.rx));
    chk({tag, "_cs_low_set"}, 64'(cs_acc), 64'(v.cs_low));
    chk({tag, "_sclk_idle"}, 64'(bus.sclk), 64'(v.cpol));
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 1'b0, 6'd0,  16'd0, 32'hA5A50F0F, 2'd0, 3'd0, 1'b0, 32'hA5A50F0F, 68,  64, 4'b0001};
    vecs[1] = '{1'b1, 1'b1, 6'd8,  16'd2, 32'h00000000, 2'd1, 3'd1, 1'b0, 32'h000000FF, 58,  16, 4'b0010};
    vecs[2] = '{1'b0, 1'b0, 6'd4,  16'd1, 32'h0000000C, 2'd0, 3'd2, 1'b0, 32'h0000000C, 23,  8,  4'b0100};
    vecs[3] = '{1'b1, 1'b0, 6'd16, 16'd0, 32'h1234ABCD, 2'd0, 3'd5, 1'b0, 32'h0000ABCD, 36,  32, 4'b0000};
    vecs[4] = '{1'b0, 1'b1, 6'd1,  16'd3, 32'h00000000, 2'd1, 3'd3, 1'b0, 32'h00000001, 21,  2,  4'b1000};
    vecs[5] = '{1'b0, 1'b1, 6'd1,  16'd0, 32'hFFFFFFFF, 2'd2, 3'd0, 1'b0, 32'h00000000, 6,   2,  4'b0001};
    vecs[6] = '{1'b0, 1'b1, 6'd40, 16'd0, 32'hFFFFFFFF, 2'd2, 3'd1, 1'b0, 32'h00000000, 68,  64, 4'b0010};
    vecs[7] = '{1'b0, 1'b1, 6'd32, 16'd1, 32'hDEADBEEF, 2'd0, 3'd0, 1'b0, 32'hDEADBEEF, 135, 64, 4'b0001};
    vecs[8] = '{1'b0, 1'b0, 6'd8,  16'd2, 32'h0000005A, 2'd0, 3'd2, 1'b1, 32'h0000005A, 58,  16, 4'b0100};
    vecs[9] = '{1'b1, 1'b0, 6'd5,  16'd0, 32'hFFFFFFE0, 2'd1, 3'd3, 1'b0, 32'h0000001F, 14,  10, 4'b1000};

    bus.start = 1'b0;
    bus.cs_sel = '0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.xfer_len = '0;
    bus.clk_div = '0;
    bus.tx_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(bus.cs_n), 64'hF);
    chk("rst_sclk", 64'(bus.sclk), 64'd0);
    chk("rst_mosi", 64'(bus.mosi), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rx", 64'(bus.rx_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) run_xfer(vecs[i], $sformatf("v%0d", i));

    // Back-to-back with start held high: mode0, len 2, H=2
    begin
      int dones = 0;
      int blo = 0;
      int chi = 0;
      int cyc = 0;
      logic pb = 1'b0;
      logic pc = 1'b1;
      @(negedge clk);
      bus.cpol = 1'b0;
      bus.cpha = 1'b0;
      bus.xfer_len = 6'd2;
      bus.clk_div = 16'd1;
      bus.tx_data = 32'h2;
      bus.cs_sel = 3'd0;
      miso_mode = 2'd0;
      bus.start = 1'b1;
      while (dones < 3 && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
        if (bus.busy && !pb && dones > 0) chk("b2b_busy_low_cycles", 64'(blo), 64'd1);
        if (bus.cs_n != 4'hF && pc && dones > 0) chk("b2b_cs_gap_ge_h1", 64'(chi >= 3), 64'd1);
        blo = bus.busy ? 0 : blo + 1;
        chi = (bus.cs_n == 4'hF) ? chi + 1 : 0;
        pb = bus.busy;
        pc = (bus.cs_n == 4'hF);
        if (bus.done) begin
          dones++;
          chk($sformatf("b2b_rx_%0d", dones), 64'(bus.rx_data), 64'h2);
        end
      end
      bus.start = 1'b0;
      chk("b2b_done_count", 64'(dones), 64'd3);
      repeat (2) @(posedge clk);
    end

    // Reset while shifting bit 10: mode0, len 32, H=2
    begin
      int dones = 0;
      @(negedge clk);
      bus.cpol = 1'b0;
      bus.cpha = 1'b0;
      bus.xfer_len = 6'd0;
      bus.clk_div = 16'd1;
      bus.tx_data = 32'hFFFF0000;
      bus.cs_sel = 3'd1;
      miso_mode = 2'd0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (42) @(posedge clk);
      #2;
      chk("mid_pre_busy", 64'(bus.busy), 64'd1);
      chk("mid_pre_sclk", 64'(bus.sclk), 64'd1);
      chk("mid_pre_mosi", 64'(bus.mosi), 64'd1);
      chk("mid_pre_cs_n", 64'(bus.cs_n), 64'hD);
      reset = 1'b1;
      #1;
      chk("mid_rst_cs_n", 64'(bus.cs_n), 64'hF);
      chk("mid_rst_sclk", 64'(bus.sclk), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_mosi", 64'(bus.mosi), 64'd0);
      chk("mid_rst_rx", 64'(bus.rx_data), 64'd0);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (bus.done) dones++;
        if (c == 2) reset = 1'b0;
      end
      chk("mid_rst_no_done", 64'(dones), 64'd0);
      run_xfer(vecs[2], "post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
